validacion_dato: RTL and testbench
==================================

VALIDACION_DATO -- requirements
Module: validacion_dato

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  8  PS/2 keyboard scan code; 8'h00 = no key.
REQ-005 senal_corriente  output  3  selected current level, 0..7, registered.
REQ-006 senal_humo  output  1  smoke flag, 1 = smoke present, registered.

Function
REQ-007 The block SHALL hold a register prev_code (8 bits), loaded with data_in on every rising clk edge.
REQ-008 The block SHALL hold a register brk (1 bit), the break-pending flag.
REQ-009 A code event SHALL occur on a rising edge when both hold:
  - data_in != 8'h00
  - data_in != prev_code
REQ-010 A held or repeated identical code SHALL produce only one event.
REQ-011 A new event for the same code SHALL need an intervening different value, for example 8'h00.
REQ-012 On an event with data_in = 8'hF0, brk SHALL be set to 1 and both outputs SHALL hold.
REQ-013 On any other event while brk = 1, brk SHALL clear, the code SHALL be discarded and both outputs SHALL hold.
REQ-014 On an event with brk = 0, the code SHALL be decoded as follows, with the outputs changing at that same edge (1-cycle latency from data_in):
  - 8'h16 (key 1) -> senal_corriente = 0
  - 8'h1E (key 2) -> 1
  - 8'h26 (key 3) -> 2
  - 8'h25 (key 4) -> 3
  - 8'h2E (key 5) -> 4
  - 8'h36 (key 6) -> 5
  - 8'h3D (key 7) -> 6
  - 8'h3E (key 8) -> 7
  - 8'h33 (H) -> senal_humo = 1
  - 8'h31 (N) -> senal_humo = 0
REQ-015 A digit event SHALL leave senal_humo unchanged, and an H or N event SHALL leave senal_corriente unchanged.
REQ-016 All other codes (8'h5A Enter, 8'h24 E, etc.) SHALL be invalid events: outputs hold and brk is unaffected.
REQ-017 Outputs SHALL change only on a valid event or on reset, and SHALL otherwise hold indefinitely.
REQ-018 Both outputs SHALL be driven directly from flip-flops, with no combinational path from data_in.

Reset
REQ-019 While reset = 1, independent of clk, the registers SHALL take these values:
  - senal_corriente = 3'b000
  - senal_humo = 0
  - prev_code = 8'h00
  - brk = 0
REQ-020 A reset asserted mid-sequence SHALL discard any pending break.
REQ-021 After reset release, the first nonzero code SHALL be treated as a new event.
REQ-022 Reset SHALL take priority over any simultaneous event.

Verification
REQ-023 Post-reset check: reset pulse, then idle 8'h00 -> senal_corriente = 0 and senal_humo = 0.
REQ-024 Digit and smoke keys: 00, 2E, 00, 3E, 00, 33 -> senal_corriente = 4 then 7, then senal_humo = 1 with senal_corriente still 7.
REQ-025 Held and repeated codes: 31 held for 5 cycles -> one event, senal_humo = 0; then 31, 33, 00, 31 -> senal_humo = 0, 1, 0.
REQ-026 Invalid codes: after 1E is applied, 24, 5A, 00 -> senal_corriente stays 1 and senal_humo is unchanged.
REQ-027 Break handling: 3D, then F0, 3D, then 00, 16 -> senal_corriente = 6 and stays 6 through F0 3D, then becomes 0.
REQ-028 Reset mid-run: senal_corriente = 5 and senal_humo = 1, reset asserted off-edge while data_in = 26 -> outputs 0 immediately; release, then 5A, 33 -> senal_corriente = 0, senal_humo = 1.

Source files
------------

// File: rtl/validacion_dato.sv
// PS/2 scan-code decoder: digit keys select a current level (0..7), H/N set/clear the smoke flag.
// Latency 1 cycle from data_in; no backpressure, every clock samples data_in.
module validacion_dato (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    output logic [2:0] senal_corriente,
    output logic       senal_humo
);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_H     = 8'h33;
    localparam logic [7:0] CODE_N     = 8'h31;

    logic [7:0] prev_code;
    logic       brk;
    logic       brk_nxt;
    logic [2:0] corriente_nxt;
    logic       humo_nxt;
    logic       code_event;

    always_comb begin
        brk_nxt       = brk;
        corriente_nxt = senal_corriente;
        humo_nxt      = senal_humo;
        // An event needs a nonzero code that differs from last cycle, so held keys fire once.
        code_event    = (data_in != 8'h00) && (data_in != prev_code);

        if (code_event) begin
            if (data_in == CODE_BREAK) begin
                brk_nxt = 1'b1;
            end else if (brk) begin
                // Code following F0 is a key release: swallow it.
                brk_nxt = 1'b0;
            end else begin
                case (data_in)
                    8'h16:   corriente_nxt = 3'd0;
                    8'h1E:   corriente_nxt = 3'd1;
                    8'h26:   corriente_nxt = 3'd2;
                    8'h25:   corriente_nxt = 3'd3;
                    8'h2E:   corriente_nxt = 3'd4;
                    8'h36:   corriente_nxt = 3'd5;
                    8'h3D:   corriente_nxt = 3'd6;
                    8'h3E:   corriente_nxt = 3'd7;
                    CODE_H:  humo_nxt      = 1'b1;
                    CODE_N:  humo_nxt      = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_code       <= 8'h00;
            brk             <= 1'b0;
            senal_corriente <= 3'b000;
            senal_humo      <= 1'b0;
        end else begin
            prev_code       <= data_in;
            brk             <= brk_nxt;
            senal_corriente <= corriente_nxt;
            senal_humo      <= humo_nxt;
        end
    end

endmodule

// File: tb/tb_validacion_dato.sv
// Directed scenarios plus randomized scan-code traffic checked against a table-driven keyboard model.
module tb_validacion_dato;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [2:0] senal_corriente;
    logic       senal_humo;

    int compares   = 0;
    int mismatches = 0;

    // Reference model state: last seen code, pending release, current outputs.
    logic [7:0] m_last;
    bit         m_brk;
    int         m_cur;
    int         m_humo;

    logic [7:0] digit_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    logic [7:0] junk_codes  [4] = '{8'h5A, 8'h24, 8'h1C, 8'h29};

    validacion_dato dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .senal_corriente (senal_corriente),
        .senal_humo      (senal_humo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] code,
                         input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            mismatches++;
            $error("FAIL %s (code %h): observed %0d expected %0d", tag, code, obs, exp);
        end
    endtask

    function automatic int digit_of(input logic [7:0] c);
        for (int i = 0; i < 8; i++)
            if (digit_codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 8'h00;
        m_brk  = 1'b0;
        m_cur  = 0;
        m_humo = 0;
    endtask

    // Keyboard semantics: a press is a new nonzero code; F0 announces that the next key is a release.
    task automatic model_edge(input logic [7:0] code);
        if (code != 8'h00 && code != m_last) begin
            if (code == 8'hF0)
                m_brk = 1'b1;
            else if (m_brk)
                m_brk = 1'b0;
            else if (digit_of(code) >= 0)
                m_cur = digit_of(code);
            else if (code == 8'h33)
                m_humo = 1;
            else if (code == 8'h31)
                m_humo = 0;
        end
        m_last = code;
    endtask

    task automatic step(input logic [7:0] code);
        @(negedge clk);
        data_in = code;
        @(posedge clk);
        model_edge(code);
        #1;
        check("corriente", code, 32'(senal_corriente), 32'(m_cur));
        check("humo", code, 32'(senal_humo), 32'(m_humo));
    endtask

    // Assert reset between edges while hold_code is on data_in, then release with the bus idle.
    task automatic pulse_reset(input logic [7:0] hold_code);
        @(negedge clk);
        #2;
        reset   = 1'b1;
        data_in = hold_code;
        #1;
        model_reset();
        check("async_rst_corriente", hold_code, 32'(senal_corriente), 32'd0);
        check("async_rst_humo", hold_code, 32'(senal_humo), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_prio_corriente", hold_code, 32'(senal_corriente), 32'd0);
        check("rst_prio_humo", hold_code, 32'(senal_humo), 32'd0);
        @(negedge clk);
        data_in = 8'h00;
        reset   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 8'h00;
        model_reset();
        #1;
        check("reset_corriente", data_in, 32'(senal_corriente), 32'd0);
        check("reset_humo", data_in, 32'(senal_humo), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        step(8'h00);
        step(8'h00);
        check("idle_corriente", 8'h00, 32'(senal_corriente), 32'd0);
        check("idle_humo", 8'h00, 32'(senal_humo), 32'd0);

        step(8'h00); step(8'h2E);
        check("key5", 8'h2E, 32'(senal_corriente), 32'd4);
        step(8'h00); step(8'h3E);
        check("key8", 8'h3E, 32'(senal_corriente), 32'd7);
        step(8'h00); step(8'h33);
        check("key_h_humo", 8'h33, 32'(senal_humo), 32'd1);
        check("key_h_corriente", 8'h33, 32'(senal_corriente), 32'd7);

        repeat (5) step(8'h31);
        check("held_n", 8'h31, 32'(senal_humo), 32'd0);
        step(8'h31);
        step(8'h33);
        check("n_then_h", 8'h33, 32'(senal_humo), 32'd1);
        step(8'h00);
        step(8'h31);
        check("h_then_n", 8'h31, 32'(senal_humo), 32'd0);

        step(8'h1E); step(8'h24); step(8'h5A); step(8'h00);
        check("invalid_corriente", 8'h00, 32'(senal_corriente), 32'd1);
        check("invalid_humo", 8'h00, 32'(senal_humo), 32'd0);

        step(8'h3D);
        check("key7", 8'h3D, 32'(senal_corriente), 32'd6);
        step(8'hF0); step(8'h3D);
        check("release_ignored", 8'h3D, 32'(senal_corriente), 32'd6);
        step(8'h00); step(8'h16);
        check("key1_after_release", 8'h16, 32'(senal_corriente), 32'd0);

        step(8'h00); step(8'h36); step(8'h33);
        check("pre_rst_corriente", 8'h33, 32'(senal_corriente), 32'd5);
        check("pre_rst_humo", 8'h33, 32'(senal_humo), 32'd1);
        pulse_reset(8'h26);
        step(8'h5A); step(8'h33);
        check("post_rst_corriente", 8'h33, 32'(senal_corriente), 32'd0);
        check("post_rst_humo", 8'h33, 32'(senal_humo), 32'd1);

        // A break pending at reset must not swallow the first key afterwards.
        step(8'h3E); step(8'hF0);
        pulse_reset(8'h00);
        step(8'h3E);
        check("brk_cleared_by_rst", 8'h3E, 32'(senal_corriente), 32'd7);

        for (int n = 0; n < 600; n++) begin
            logic [7:0] c;
            case ($urandom_range(0, 11))
                0, 1:    c = 8'h00;
                2:       c = 8'hF0;
                3:       c = m_last;
                4, 5, 6: c = digit_codes[$urandom_range(0, 7)];
                7:       c = 8'h33;
                8:       c = 8'h31;
                9:       c = junk_codes[$urandom_range(0, 3)];
                10:      c = 8'($urandom);
                default: c = m_last;
            endcase
            step(c);
            if (n % 150 == 149) pulse_reset(8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
